// File: rtl/lv1_bus_req_ctrl.sv
// -----------------------------------------------------------------------------
// lv1_bus_req_ctrl
//
// Cache-to-bus request controller. It takes one CPU miss/upgrade request,
// arbitrates for the bus, issues exactly one bus command and reports the MESI
// fill state when the transaction completes.
//
// FSM: IDLE -> ARB -> WAIT -> DONE -> IDLE. Every output is a flop.
//
// Ports
//   clk, rst_n               single clock, async active-low reset
//   cpu_rd_miss              read miss        (held by the CPU until req_done)
//   cpu_wr_miss              write miss       (held by the CPU until req_done)
//   cpu_wr_hit_shared        upgrade request  (held by the CPU until req_done)
//   cpu_addr[ADDR_WID-1:0]   block address of the request
//   bus_gnt                  arbiter grant
//   data_in_bus              fill data valid, completes bus_rd / bus_rdx
//   all_invalidation_done    all snoopers acked, completes invalidate
//   shared                   another cache holds the line (sampled at completion)
//   bus_req                  arbitration request
//   bus_rd/bus_rdx/invalidate bus command, one-hot or all zero
//   bus_addr[ADDR_WID-1:0]   latched command address
//   req_done                 one-cycle completion pulse
//   new_state[1:0]           MESI fill state (I=00 S=01 E=10 M=11), valid with req_done
//   req_err                  timeout abort flag, valid with req_done
//
// Optional feature: define LV1_BUS_TIMEOUT_EN to abort a WAIT phase that lasts
// TIMEOUT_CYC cycles without completion (req_err=1, new_state=I). Without the
// macro WAIT lasts until completion and req_err is constant 0.
// -----------------------------------------------------------------------------
module lv1_bus_req_ctrl #(
  parameter int unsigned ADDR_WID    = 32,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cpu_rd_miss,
  input  logic                cpu_wr_miss,
  input  logic                cpu_wr_hit_shared,
  input  logic [ADDR_WID-1:0] cpu_addr,
  input  logic                bus_gnt,
  input  logic                data_in_bus,
  input  logic                all_invalidation_done,
  input  logic                shared,
  output logic                bus_req,
  output logic                bus_rd,
  output logic                bus_rdx,
  output logic                invalidate,
  output logic [ADDR_WID-1:0] bus_addr,
  output logic                req_done,
  output logic [1:0]          new_state,
  output logic                req_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARB  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    REQ_RD  = 2'd0,  // read miss      -> bus_rd
    REQ_RDX = 2'd1,  // write miss     -> bus_rdx
    REQ_INV = 2'd2   // upgrade        -> invalidate
  } req_e;

  localparam logic [1:0] MESI_I = 2'b00;
  localparam logic [1:0] MESI_S = 2'b01;
  localparam logic [1:0] MESI_E = 2'b10;
  localparam logic [1:0] MESI_M = 2'b11;

  state_e                state_q, state_d;
  req_e                  req_q, req_d;
  logic [ADDR_WID-1:0]   addr_q, addr_d;
  logic                  bus_req_q, bus_req_d;
  logic                  bus_rd_q, bus_rd_d;
  logic                  bus_rdx_q, bus_rdx_d;
  logic                  inv_q, inv_d;
  logic                  req_done_q, req_done_d;
  logic [1:0]            new_state_q, new_state_d;
  logic                  complete;

`ifdef LV1_BUS_TIMEOUT_EN
  localparam int unsigned           CNT_W  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0]      CNT_TO = CNT_W'(TIMEOUT_CYC);
  logic [CNT_W-1:0]                 cnt_q, cnt_d, cnt_inc;
  logic                             req_err_q, req_err_d;

  assign cnt_inc = cnt_q + 1'b1;
`endif

  // An upgrade finishes on the snoop ack, a read/rdx on fill data; the other
  // completion input is deliberately ignored.
  assign complete = (req_q == REQ_INV) ? all_invalidation_done : data_in_bus;

  // NOTE: combinational next-state logic uses blocking '=', the flop block
  // below uses non-blocking '<='; mixing them up creates sim/synth mismatches.
  always_comb begin
    // NOTE: every *_d gets a default first, so no path can infer a latch.
    state_d     = state_q;
    req_d       = req_q;
    addr_d      = addr_q;
    bus_req_d   = bus_req_q;
    bus_rd_d    = bus_rd_q;
    bus_rdx_d   = bus_rdx_q;
    inv_d       = inv_q;
    req_done_d  = 1'b0;
    new_state_d = new_state_q;
`ifdef LV1_BUS_TIMEOUT_EN
    cnt_d       = cnt_q;
    req_err_d   = req_err_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (cpu_wr_miss || cpu_wr_hit_shared || cpu_rd_miss) begin
          // Only the highest-priority request is latched.
          if (cpu_wr_miss)            req_d = REQ_RDX;
          else if (cpu_wr_hit_shared) req_d = REQ_INV;
          else                        req_d = REQ_RD;
          addr_d    = cpu_addr;
          bus_req_d = 1'b1;
          state_d   = ST_ARB;
        end
      end

      ST_ARB: begin
        if (bus_gnt) begin
          bus_rd_d  = (req_q == REQ_RD);
          bus_rdx_d = (req_q == REQ_RDX);
          inv_d     = (req_q == REQ_INV);
          state_d   = ST_WAIT;
`ifdef LV1_BUS_TIMEOUT_EN
          cnt_d     = '0;
`endif
        end
      end

      ST_WAIT: begin
        // Completion is checked first so it wins over a same-cycle timeout.
        if (complete) begin
          bus_req_d   = 1'b0;
          bus_rd_d    = 1'b0;
          bus_rdx_d   = 1'b0;
          inv_d       = 1'b0;
          req_done_d  = 1'b1;
          new_state_d = (req_q == REQ_RD) ? (shared ? MESI_S : MESI_E) : MESI_M;
          state_d     = ST_DONE;
`ifdef LV1_BUS_TIMEOUT_EN
          req_err_d   = 1'b0;
        end else begin
          // cnt_inc counts the WAIT cycles elapsed including this one.
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_TO) begin
            bus_req_d   = 1'b0;
            bus_rd_d    = 1'b0;
            bus_rdx_d   = 1'b0;
            inv_d       = 1'b0;
            req_done_d  = 1'b1;
            new_state_d = MESI_I;
            req_err_d   = 1'b1;
            state_d     = ST_DONE;
          end
`endif
        end
      end

      ST_DONE: begin
        // Fill state and error are only meaningful during the req_done pulse.
        new_state_d = MESI_I;
`ifdef LV1_BUS_TIMEOUT_EN
        req_err_d   = 1'b0;
`endif
        state_d     = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      req_q       <= REQ_RD;
      addr_q      <= '0;
      bus_req_q   <= 1'b0;
      bus_rd_q    <= 1'b0;
      bus_rdx_q   <= 1'b0;
      inv_q       <= 1'b0;
      req_done_q  <= 1'b0;
      new_state_q <= MESI_I;
`ifdef LV1_BUS_TIMEOUT_EN
      cnt_q       <= '0;
      req_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      addr_q      <= addr_d;
      bus_req_q   <= bus_req_d;
      bus_rd_q    <= bus_rd_d;
      bus_rdx_q   <= bus_rdx_d;
      inv_q       <= inv_d;
      req_done_q  <= req_done_d;
      new_state_q <= new_state_d;
`ifdef LV1_BUS_TIMEOUT_EN
      cnt_q       <= cnt_d;
      req_err_q   <= req_err_d;
`endif
    end
  end

  assign bus_req    = bus_req_q;
  assign bus_rd     = bus_rd_q;
  assign bus_rdx    = bus_rdx_q;
  assign invalidate = inv_q;
  assign bus_addr   = addr_q;
  assign req_done   = req_done_q;
  assign new_state  = new_state_q;
`ifdef LV1_BUS_TIMEOUT_EN
  assign req_err    = req_err_q;
`else
  assign req_err    = 1'b0;
`endif

endmodule

// File: tb/tb_lv1_bus_req_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lv1_bus_req_ctrl
//
// Scoreboard bench for lv1_bus_req_ctrl. The driver issues CPU requests and
// pushes the expected bus command, address, fill state and error flag into a
// queue; an independent monitor compares the command while it is on the bus
// and pops the entry on every req_done pulse. The driver additionally checks
// cycle-exact latencies. Directed cases cover reads with/without sharers, an
// upgrade with fill-data noise, request priority with the post-DONE IDLE gap,
// reset mid-transaction and (when LV1_BUS_TIMEOUT_EN is defined) the timeout.
// -----------------------------------------------------------------------------
module tb_lv1_bus_req_ctrl;

  localparam int AW = 32;
  localparam int TO = 8;

  logic          clk;
  logic          rst_n;
  logic          cpu_rd_miss, cpu_wr_miss, cpu_wr_hit_shared;
  logic [AW-1:0] cpu_addr;
  logic          bus_gnt, data_in_bus, all_invalidation_done, shared;
  logic          bus_req, bus_rd, bus_rdx, invalidate;
  logic [AW-1:0] bus_addr;
  logic          req_done;
  logic [1:0]    new_state;
  logic          req_err;
  logic [2:0]    cmd_o;

  assign cmd_o = {bus_rd, bus_rdx, invalidate};

  lv1_bus_req_ctrl #(.ADDR_WID(AW), .TIMEOUT_CYC(TO)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .cpu_rd_miss           (cpu_rd_miss),
    .cpu_wr_miss           (cpu_wr_miss),
    .cpu_wr_hit_shared     (cpu_wr_hit_shared),
    .cpu_addr              (cpu_addr),
    .bus_gnt               (bus_gnt),
    .data_in_bus           (data_in_bus),
    .all_invalidation_done (all_invalidation_done),
    .shared                (shared),
    .bus_req               (bus_req),
    .bus_rd                (bus_rd),
    .bus_rdx               (bus_rdx),
    .invalidate            (invalidate),
    .bus_addr              (bus_addr),
    .req_done              (req_done),
    .new_state             (new_state),
    .req_err               (req_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outcome of one transaction: command {rd,rdx,inv}, address,
  // MESI fill state and error flag.
  typedef struct {
    logic [2:0]    cmd;
    logic [AW-1:0] addr;
    logic [1:0]    st;
    logic          err;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: priority wr_miss > upgrade > rd_miss, MESI fill rules.
  function automatic exp_t model(input bit rd, input bit wr, input bit up,
                                 input logic [AW-1:0] a, input bit sh, input bit to);
    exp_t e;
    e.addr = a;
    e.err  = 1'b0;
    if (wr) begin
      e.cmd = 3'b010; e.st = 2'b11;
    end else if (up) begin
      e.cmd = 3'b001; e.st = 2'b11;
    end else begin
      e.cmd = 3'b100; e.st = sh ? 2'b01 : 2'b10;
    end
    if (to) begin
      e.st  = 2'b00;
      e.err = 1'b1;
    end
    return e;
  endfunction

  // ---------------------------------------------------------------- monitor
  initial begin : monitor
    bit   cmd_seen;
    exp_t e;
    cmd_seen = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cmd_seen = 1'b0;
      end else if (req_done) begin
        if (sb.size() == 0) begin
          check("spurious_req_done", req_done, 1'b0);
        end else begin
          e = sb.pop_front();
          check("new_state", new_state, e.st);
          check("req_err", req_err, e.err);
          check("cmd_off_in_done", cmd_o, 3'b000);
          check("bus_req_off_in_done", bus_req, 1'b0);
        end
        cmd_seen = 1'b0;
      end else if (cmd_o != 3'b000 || cmd_seen) begin
        if (sb.size() == 0) begin
          check("cmd_without_txn", cmd_o, 3'b000);
        end else begin
          check("bus_cmd", cmd_o, sb[0].cmd);
          check("bus_addr", bus_addr, sb[0].addr);
          check("bus_req_in_wait", bus_req, 1'b1);
          cmd_seen = 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------- driver
  // Raise a request during an IDLE cycle; bus_req must follow one edge later.
  task automatic issue(input bit rd, input bit wr, input bit up,
                       input logic [AW-1:0] a, input bit sh, input bit to);
    @(negedge clk);
    cpu_rd_miss       = rd;
    cpu_wr_miss       = wr;
    cpu_wr_hit_shared = up;
    cpu_addr          = a;
    sb.push_back(model(rd, wr, up, a, sh, to));
    @(negedge clk);
    check("req_latency", bus_req, 1'b1);
  endtask

  // Called at the first ARB negedge. comp_dly < 0 means never complete.
  task automatic drive_bus(input bit is_inv, input int gnt_dly, input int comp_dly,
                           input bit sh, input bit hold, input bit scramble);
    int n;
    for (int i = 0; i < gnt_dly; i++) begin
      bus_gnt = 1'b0;
      if (scramble) begin
        {cpu_rd_miss, cpu_wr_miss, cpu_wr_hit_shared} = 3'($urandom);
        cpu_addr = $urandom;
      end
      @(negedge clk);
      check("arb_hold_req", bus_req, 1'b1);
      check("arb_no_cmd", cmd_o, 3'b000);
    end
    bus_gnt = 1'b1;
    @(negedge clk);
    check("cmd_latency", (cmd_o != 3'b000), 1'b1);

    n = 0;
    while (comp_dly < 0 || n < comp_dly) begin
      bus_gnt = 1'($urandom);
      shared  = 1'($urandom);
      if (is_inv) begin
        data_in_bus = 1'($urandom); all_invalidation_done = 1'b0;
      end else begin
        all_invalidation_done = 1'($urandom); data_in_bus = 1'b0;
      end
      if (scramble) begin
        {cpu_rd_miss, cpu_wr_miss, cpu_wr_hit_shared} = 3'($urandom);
        cpu_addr = $urandom;
      end
      @(negedge clk);
      n++;
      if (comp_dly < 0 && (req_done || n > 40)) break;
    end

    if (comp_dly < 0) begin
      check("timeout_wait_cycles", n, TO);
    end else begin
      shared = sh;
      if (is_inv) begin
        all_invalidation_done = 1'b1; data_in_bus = 1'($urandom);
      end else begin
        data_in_bus = 1'b1; all_invalidation_done = 1'($urandom);
      end
      @(negedge clk);
      check("done_latency", req_done, 1'b1);
    end
    bus_gnt = 1'b0;
    data_in_bus = 1'b0;
    all_invalidation_done = 1'b0;
    shared = 1'b0;
    if (!hold) begin
      cpu_rd_miss = 1'b0; cpu_wr_miss = 1'b0; cpu_wr_hit_shared = 1'b0;
    end
  endtask

  task automatic clear_inputs();
    cpu_rd_miss = 1'b0; cpu_wr_miss = 1'b0; cpu_wr_hit_shared = 1'b0;
    cpu_addr = '0; bus_gnt = 1'b0; data_in_bus = 1'b0;
    all_invalidation_done = 1'b0; shared = 1'b0;
  endtask

  function automatic logic [AW+7:0] all_outputs();
    return {bus_req, cmd_o, req_done, req_err, new_state, bus_addr};
  endfunction

  initial begin : stimulus
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    check("reset_outputs", all_outputs(), '0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", all_outputs(), '0);

    // Read miss, no sharers -> E.
    issue(1, 0, 0, 32'h100, 0, 0);
    drive_bus(0, 2, 2, 0, 0, 0);
    // Read miss, shared -> S.
    issue(1, 0, 0, 32'h100, 1, 0);
    drive_bus(0, 2, 2, 1, 0, 0);
    // Upgrade with fill-data noise -> invalidate only, M.
    issue(0, 0, 1, 32'h2C0, 0, 0);
    drive_bus(1, 0, 3, 0, 0, 0);

    // Simultaneous rd+wr miss held through DONE: rdx wins, one IDLE cycle, re-accept.
    issue(1, 1, 0, 32'h340, 0, 0);
    drive_bus(0, 0, 1, 0, 1, 0);
    sb.push_back(model(1, 1, 0, 32'h340, 0, 0));
    @(negedge clk);
    check("idle_gap_no_req", bus_req, 1'b0);
    @(negedge clk);
    check("accept_after_gap", bus_req, 1'b1);
    drive_bus(0, 1, 0, 0, 0, 0);

    // Reset in the middle of a bus_rdx.
    issue(0, 1, 0, 32'hABC0, 0, 0);
    bus_gnt = 1'b1;
    @(negedge clk);
    check("rst_test_rdx", cmd_o, 3'b010);
    bus_gnt = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("reset_mid_wait", all_outputs(), '0);
    sb.delete();
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("no_done_after_reset", {req_done, bus_req}, 2'b00);
    end

`ifdef LV1_BUS_TIMEOUT_EN
    // No completion: abort after TO WAIT cycles with req_err=1, state I.
    issue(0, 1, 0, 32'h500, 0, 1);
    drive_bus(0, 1, -1, 0, 0, 0);
    // Completion in the last WAIT cycle wins over the timeout.
    issue(1, 0, 0, 32'h540, 1, 0);
    drive_bus(0, 0, TO - 1, 1, 0, 0);
`endif

    // Randomized transactions.
    for (int t = 0; t < 30; t++) begin
      bit            rd, wr, up, sh, scr;
      logic [AW-1:0] a;
      int            gd, cd;
      {rd, wr, up} = 3'($urandom_range(1, 7));
      a   = $urandom;
      sh  = 1'($urandom);
      scr = 1'($urandom);
      gd  = $urandom_range(0, 3);
      cd  = $urandom_range(0, 4);
      issue(rd, wr, up, a, sh, 0);
      drive_bus(!wr && up, gd, cd, sh, 0, scr);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
